// File: rtl/ssd_scan_display.sv
// Multi-digit seven-segment scanner with a sequential double-dabble binary-to-BCD converter.
// Optional build macro: LEADING_ZERO_BLANK_EN (blank digits above the most significant non-zero one).

module ssd_dd_nibble (
  input  logic [3:0] nib_in,
  output logic [3:0] nib_out
);
  assign nib_out = (nib_in >= 4'd5) ? nib_in + 4'd3 : nib_in;
endmodule

module ssd_scan_display #(
  parameter int NUM_DIGITS = 4,
  parameter int DATA_W     = 14,
  parameter int SCAN_CNT   = 100000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_W-1:0]     i_data,
  input  logic                  i_load,
  output logic                  o_busy,
  output logic                  o_ovf,
  output logic [7:0]            D_ssd,
  output logic [NUM_DIGITS-1:0] d
);
  localparam int BCD_W = 4*NUM_DIGITS;
  localparam int CNT_W = $clog2(DATA_W+1);
  localparam int PS_W  = (SCAN_CNT > 1) ? $clog2(SCAN_CNT) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PS_W-1:0]  PS_MAX  = PS_W'(SCAN_CNT-1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS-1);
  localparam logic [CNT_W-1:0] CNT_LD  = CNT_W'(DATA_W);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                       state;
  logic [DATA_W-1:0]            bin_reg;
  logic [NUM_DIGITS:0][3:0]     work, work_adj;
  logic [BCD_W+3:0]             adj_flat;
  logic [CNT_W-1:0]             shift_cnt;
  logic [NUM_DIGITS-1:0][3:0]   disp;
  logic [PS_W-1:0]              ps;
  logic [IDX_W-1:0]             idx, idx_nxt;
  logic [7:0]                   seg_nxt;

  function automatic logic [7:0] seg_decode(input logic [3:0] n);
    case (n)
      4'd0: seg_decode = 8'h03;
      4'd1: seg_decode = 8'h9F;
      4'd2: seg_decode = 8'h25;
      4'd3: seg_decode = 8'h0D;
      4'd4: seg_decode = 8'h99;
      4'd5: seg_decode = 8'h49;
      4'd6: seg_decode = 8'h41;
      4'd7: seg_decode = 8'h1F;
      4'd8: seg_decode = 8'h01;
      4'd9: seg_decode = 8'h09;
      default: seg_decode = 8'hFF;
    endcase
  endfunction

  // Guard nibble included so overflow shows up as a non-zero top digit.
  for (genvar g = 0; g <= NUM_DIGITS; g++) begin : g_adj
    ssd_dd_nibble u_adj (.nib_in(work[g]), .nib_out(work_adj[g]));
  end
  assign adj_flat = work_adj;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bin_reg   <= '0;
      work      <= '0;
      shift_cnt <= '0;
      disp      <= '0;
      o_busy    <= 1'b0;
      o_ovf     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (i_load) begin
          bin_reg   <= i_data;
          work      <= '0;
          shift_cnt <= CNT_LD;
          o_busy    <= 1'b1;
          state     <= SHIFT;
        end
        SHIFT: begin
          work      <= {adj_flat[BCD_W+2:0], bin_reg[DATA_W-1]};
          bin_reg   <= bin_reg << 1;
          shift_cnt <= shift_cnt - 1'b1;
          if (shift_cnt == CNT_W'(1)) state <= DONE;
        end
        DONE: begin
          if (work[NUM_DIGITS] == 4'd0) begin
            disp  <= work[NUM_DIGITS-1:0];
            o_ovf <= 1'b0;
          end else begin
            o_ovf <= 1'b1;
          end
          o_busy <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    idx_nxt = idx;
    if (ps == PS_MAX) idx_nxt = (idx == IDX_MAX) ? '0 : idx + 1'b1;
  end

  // Segments are computed for the digit that will be enabled next, so d and D_ssd switch together.
  always_comb begin
    seg_nxt = seg_decode(disp[idx_nxt]);
`ifdef LEADING_ZERO_BLANK_EN
    begin
      logic blank;
      blank = (idx_nxt != '0);
      for (int i = 0; i < NUM_DIGITS; i++)
        if (i >= int'(idx_nxt) && disp[i] != 4'd0) blank = 1'b0;
      if (blank) seg_nxt = 8'hFF;
    end
`endif
    if (o_ovf) seg_nxt = 8'hFD;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ps    <= '0;
      idx   <= '0;
      d     <= ~NUM_DIGITS'(1);
      D_ssd <= 8'h03;
    end else begin
      ps    <= (ps == PS_MAX) ? '0 : ps + 1'b1;
      idx   <= idx_nxt;
      d     <= ~(NUM_DIGITS'(1) << idx_nxt);
      D_ssd <= seg_nxt;
    end
  end
endmodule

// File: tb/tb_ssd_scan_display.sv
// Directed bench for ssd_scan_display (4 digits, 14-bit input, 4-cycle scan slot).
module tb_ssd_scan_display;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [13:0] i_data = '0;
  logic        i_load = 1'b0;
  logic        o_busy, o_ovf;
  logic [7:0]  D_ssd;
  logic [3:0]  d;
  int          n_chk = 0;
  int          n_err = 0;

  ssd_scan_display #(.NUM_DIGITS(4), .DATA_W(14), .SCAN_CNT(4)) dut (
    .clk(clk), .rst_n(rst_n), .i_data(i_data), .i_load(i_load),
    .o_busy(o_busy), .o_ovf(o_ovf), .D_ssd(D_ssd), .d(d)
  );

  always #5 clk = ~clk;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [7:0] LZ = 8'hFF;
`else
  localparam logic [7:0] LZ = 8'h03;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [13:0] v);
    @(negedge clk);
    i_data = v; i_load = 1'b1;
    @(negedge clk);
    i_load = 1'b0;
  endtask

  // Wait (bounded) for digit k to be enabled, then check its segments.
  task automatic chk_digit(input string tag, input int k, input logic [7:0] exp);
    logic [3:0] en;
    int n;
    en = 4'b0001 << k;
    en = ~en;
    n = 0;
    while (d !== en && n < 40) begin @(negedge clk); n++; end
    chk({tag, "_en"}, {28'd0, d}, {28'd0, en});
    chk(tag, {24'd0, D_ssd}, {24'd0, exp});
  endtask

  initial begin
    logic [3:0] walk;
    // 1. reset state and scan walk
    #12;
    chk("rst_d", {28'd0, d}, 32'hE);
    chk("rst_seg", {24'd0, D_ssd}, 32'h03);
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    chk("rst_ovf", {31'd0, o_ovf}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    for (int n = 1; n <= 16; n++) begin
      @(negedge clk);
      walk = 4'b0001 << ((n / 4) % 4);
      chk($sformatf("walk%0d", n), {28'd0, d}, {28'd0, ~walk});
    end

    // 2. 1234
    do_load(14'd1234);
    chk("busy_start", {31'd0, o_busy}, 32'd1);
    cycles(13);
    chk("busy_mid", {31'd0, o_busy}, 32'd1);
    cycles(2);
    chk("busy_end", {31'd0, o_busy}, 32'd0);
    chk("ovf_1234", {31'd0, o_ovf}, 32'd0);
    chk_digit("d3_1234", 3, 8'h9F);
    chk_digit("d2_1234", 2, 8'h25);
    chk_digit("d1_1234", 1, 8'h0D);
    chk_digit("d0_1234", 0, 8'h99);

    // 3. overflow then recovery
    do_load(14'd12000);
    cycles(20);
    chk("ovf_set", {31'd0, o_ovf}, 32'd1);
    chk_digit("d3_ovf", 3, 8'hFD);
    chk_digit("d0_ovf", 0, 8'hFD);
    do_load(14'd42);
    cycles(20);
    chk("ovf_clr", {31'd0, o_ovf}, 32'd0);
    chk_digit("d3_42", 3, LZ);
    chk_digit("d2_42", 2, LZ);
    chk_digit("d1_42", 1, 8'h99);
    chk_digit("d0_42", 0, 8'h25);

    // 4. second strobe while busy is dropped
    do_load(14'd1234);
    cycles(4);
    i_data = 14'd9999; i_load = 1'b1;
    @(negedge clk); i_load = 1'b0;
    cycles(25);
    chk_digit("d3_ign", 3, 8'h9F);
    chk_digit("d1_ign", 1, 8'h0D);
    chk_digit("d0_ign", 0, 8'h99);

    // decode of 6..9
    do_load(14'd9876);
    cycles(20);
    chk_digit("d3_9876", 3, 8'h09);
    chk_digit("d2_9876", 2, 8'h01);
    chk_digit("d1_9876", 1, 8'h1F);
    chk_digit("d0_9876", 0, 8'h41);

    // 5. reset mid-conversion
    do_load(14'd5678);
    cycles(7);
    chk("busy_pre_rst", {31'd0, o_busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("busy_async_rst", {31'd0, o_busy}, 32'd0);
    chk("d_async_rst", {28'd0, d}, 32'hE);
    chk("seg_async_rst", {24'd0, D_ssd}, 32'h03);
    @(negedge clk); rst_n = 1'b1;
    cycles(20);
    chk("busy_after_rst", {31'd0, o_busy}, 32'd0);
    chk_digit("d3_rst", 3, LZ);
    chk_digit("d0_rst", 0, 8'h03);

    // 6. zero value after a non-zero one
    do_load(14'd1234);
    cycles(20);
    do_load(14'd0);
    cycles(20);
    chk_digit("d3_zero", 3, LZ);
    chk_digit("d1_zero", 1, LZ);
    chk_digit("d0_zero", 0, 8'h03);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
